// File: rtl/emergency_phase_timer.sv
// emergency_phase_timer: preempts the normal signal controller for a decoded emergency lane set.
// Latency: all outputs are registered; a state shows on the lamps one cycle after it is entered.
// Backpressure: none; inputs are sampled every cycle and tick gates every countdown.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   tick                  timebase enable, countdowns move only when high
//   emgMask, loadTime     decoded emergency green mask and its green duration in ticks
//   normalGreen           green mask requested by the normal controller
//   greenMask, yellowMask lamp drive outputs (never overlap)
//   overrideActive        high whenever the sequencer is not idle
//   timeRemaining         current countdown value
//   done                  one-cycle pulse when control returns to the normal controller
// Build option: define EMG_EXTEND_EN to let a held, unchanged request keep extending green.
module emergency_phase_timer #(
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [0:7] emgMask,
  input  logic [6:0] loadTime,
  input  logic [0:7] normalGreen,
  output logic [0:7] greenMask,
  output logic [0:7] yellowMask,
  output logic       overrideActive,
  output logic [6:0] timeRemaining,
  output logic       done
);

  localparam logic [6:0] YT = 7'(YELLOW_TIME);
  localparam logic [6:0] AT = 7'(ALLRED_TIME);

  typedef enum logic [2:0] {
    IDLE,
    PRE_YELLOW,
    PRE_RED,
    EMG_GREEN,
    EXIT_YELLOW,
    EXIT_RED
  } stateT;

  stateT      state, stateNext;
  logic [6:0] counter, counterNext;
  logic [0:7] eMask, eMaskNext;   // lanes being served
  logic [0:7] cMask, cMaskNext;   // conflicting lanes being cleared
  logic       heldReq, heldReqNext;
  logic       exitPulse;
  logic       req;
  logic       expire;
  logic [6:0] effLoad;
  logic [0:7] greenNext, yellowNext;

  assign req     = |emgMask;
  assign expire  = tick && (counter == 7'd1);
  assign effLoad = (loadTime == 7'd0) ? 7'd1 : loadTime;

  // heldReq marks the request that was just served and is still held unchanged.
  // It must run the exit sequence back to IDLE rather than abort in EXIT_RED;
  // only a request that differs from it (or was re-raised) counts as new there.
  always_comb begin : nextStateLogic
    stateNext   = state;
    counterNext = counter;
    eMaskNext   = eMask;
    cMaskNext   = cMask;
    heldReqNext = heldReq && req && (emgMask == eMask);
    if (tick && (counter > 7'd1)) begin
      counterNext = counter - 7'd1;
    end
    case (state)
      IDLE: begin
        counterNext = '0;
        if (req) begin
          eMaskNext = emgMask;
          cMaskNext = normalGreen & ~emgMask;
          if ((normalGreen & ~emgMask) == '0) begin
            stateNext   = EMG_GREEN;
            counterNext = effLoad;
          end else begin
            stateNext   = PRE_YELLOW;
            counterNext = YT;
          end
        end
      end
      PRE_YELLOW: begin
        if (expire) begin
          stateNext   = PRE_RED;
          counterNext = AT;
        end
      end
      PRE_RED: begin
        if (expire) begin
          stateNext   = EMG_GREEN;
          counterNext = effLoad;
        end
      end
      EMG_GREEN: begin
        if (expire) begin
          if (req && (emgMask == eMask)) begin
`ifdef EMG_EXTEND_EN
            counterNext = effLoad;
`else
            stateNext   = EXIT_YELLOW;
            counterNext = YT;
            heldReqNext = 1'b1;
`endif
          end else if (req) begin
            // Lanes dropped from the new mask must be cleared before re-serving.
            cMaskNext = eMask & ~emgMask;
            eMaskNext = emgMask;
            if ((eMask & ~emgMask) == '0) begin
              stateNext   = EMG_GREEN;
              counterNext = effLoad;
            end else begin
              stateNext   = PRE_YELLOW;
              counterNext = YT;
            end
          end else begin
            stateNext   = EXIT_YELLOW;
            counterNext = YT;
          end
        end
      end
      EXIT_YELLOW: begin
        if (expire) begin
          stateNext   = EXIT_RED;
          counterNext = AT;
        end
      end
      EXIT_RED: begin
        // Everything is already red, so a new request goes straight to green.
        if (req && !(heldReq && (emgMask == eMask))) begin
          eMaskNext   = emgMask;
          cMaskNext   = '0;
          stateNext   = EMG_GREEN;
          counterNext = effLoad;
        end else if (expire) begin
          stateNext   = IDLE;
          counterNext = '0;
        end
      end
      default: begin
        stateNext   = IDLE;
        counterNext = '0;
      end
    endcase
  end

  always_comb begin : lampLogic
    greenNext  = '0;
    yellowNext = '0;
    case (state)
      IDLE:        greenNext = normalGreen;
      PRE_YELLOW: begin
        greenNext  = normalGreen & eMask;
        yellowNext = cMask;
      end
      EMG_GREEN:   greenNext = eMask;
      EXIT_YELLOW: yellowNext = eMask;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin : stateReg
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      eMask     <= '0;
      cMask     <= '0;
      heldReq   <= 1'b0;
      exitPulse <= 1'b0;
    end else begin
      state     <= stateNext;
      counter   <= counterNext;
      eMask     <= eMaskNext;
      cMask     <= cMaskNext;
      heldReq   <= heldReqNext;
      exitPulse <= (state == EXIT_RED) && (stateNext == IDLE);
    end
  end

  always_ff @(posedge clk) begin : outputReg
    if (reset) begin
      greenMask      <= '0;
      yellowMask     <= '0;
      overrideActive <= 1'b0;
      timeRemaining  <= '0;
      done           <= 1'b0;
    end else begin
      greenMask      <= greenNext;
      yellowMask     <= yellowNext;
      overrideActive <= (state != IDLE);
      timeRemaining  <= counter;
      done           <= exitPulse;
    end
  end

endmodule
